req_arbiter_4: RTL and testbench
================================

Name: req_arbiter_4

Overview:
- Sequential 4-requester arbiter that shares one downstream resource (the 2-to-4 decoded select lines) between four requesters.
- Encodes the winning request to a 2-bit index and holds a one-hot grant until the owner releases it or a hold timeout expires.
- Sits between requester logic and the shared priority decoder/datapath; it drives the decoder inputs (gnt_id) plus a qualified one-hot grant.

Parameters:
- NUM_REQ, 4, number of requesters; only 4 is supported (index width fixed at 2).
- MAX_HOLD, 8, maximum grant cycles before forced release; legal range 2..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector, level-sensitive, one bit per requester.
- done  input  4  release strobe from each requester; only the owner's bit is honoured.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- gnt_id  output  2  index of current owner, registered; drives decoder select.
- gnt_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, rr_ptr=0. Outputs clear immediately, not at the next edge; a grant held at reset assertion is dropped.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if req!=0 at a rising edge, latch the winner into gnt/gnt_id, set gnt_valid=1 and hold_cnt=1, and go to GRANT. Grant latency is 1 cycle from req being sampled high. If req==0, stay in IDLE.
- Default arbitration is fixed priority: req[3] highest, req[0] lowest.
- GRANT exits to RELEASE at the first edge where any of these holds:
  - done[gnt_id]=1
  - req[gnt_id]=0 (owner withdrew)
  - hold_cnt==MAX_HOLD; in this case timeout=1 for exactly that next cycle.
- Otherwise in GRANT: hold_cnt increments and the grant is held stable. Requests from other requesters never pre-empt the owner.
- done bits from non-owners are ignored in every state.
- RELEASE: gnt=0, gnt_valid=0, gnt_id keeps its last value. This is a one-cycle dead bubble guaranteeing break-before-make. Go to IDLE unconditionally.
- Minimum spacing between two grants is therefore 3 cycles: GRANT(>=1), RELEASE, IDLE sample.
- Simultaneous done and timeout: treated as a normal release; timeout is not pulsed.
- gnt is always one-hot or zero; gnt == (1 << gnt_id) whenever gnt_valid=1.
- hold_cnt saturates at MAX_HOLD and never wraps.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. rr_ptr (2 bits) names the highest-priority index; priority descends cyclically from rr_ptr.
  - On entering RELEASE, rr_ptr = gnt_id+1 mod 4, so the last owner becomes lowest priority.
  - rr_ptr resets to 0, so requester 0 is highest priority after reset.
- Undefined: fixed priority (req[3] highest); rr_ptr logic is absent.

Decomposition:
- Package arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - NUM_REQ, ID_W=2
  - default MAX_HOLD
- Sub-module arb_prio_enc, combinational:
  - inputs: req[3:0], rr_ptr[1:0]
  - outputs: win_id[1:0], win_valid
  - rr_ptr is tied to 0 (fixed priority) when the macro is off.
- The top module holds the FSM, hold counter, rr_ptr and output registers.

Test Plan:
- Reset mid-grant: req=4'b0100 held for 3 cycles, then assert rst_n=0 -> gnt=0 and gnt_valid=0 immediately, before the next clock edge.
- Fixed priority: req=4'b1011 from IDLE -> 1 cycle later gnt=4'b1000, gnt_id=2'd3. Pulse done[3] -> next cycle gnt=0 (RELEASE), then req still 4'b0011 -> gnt=4'b0010 two cycles later.
- No pre-emption: req[0] granted, then raise req[3] -> gnt stays 4'b0001 until done[0]. done[2] pulsed while req[0] owns -> ignored.
- Timeout: MAX_HOLD=4, req[1] held high, no done -> gnt=4'b0010 for 4 cycles, then timeout=1 for exactly 1 cycle with gnt=0. Regrant to 1 follows (fixed priority).
- Owner withdraw: req[2] granted, then drop req[2] -> RELEASE next edge, timeout stays 0.
- ARB_ROUND_ROBIN_EN defined, req=4'b1111 held with done pulsed each grant -> grant order 0,1,2,3,0, each separated by one RELEASE cycle.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the 4-requester arbiter.
//                State encoding for the arbiter FSM, requester count, grant
//                index width and the default hold limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM encoding (value 2'd3 is unused and recovers to IDLE)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int NUM_REQ          = 4;
    localparam int ID_W             = 2;
    localparam int DEFAULT_MAX_HOLD = 8;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : arb_prio_enc
//  Description : Combinational request encoder. Picks the winning requester
//                index from a 4-bit request vector.
//                Build option ARB_ROUND_ROBIN_EN:
//                  defined   - rr_ptr is the highest-priority index, priority
//                              falls cyclically rr_ptr, rr_ptr+1, ...
//                  undefined - fixed priority, req[3] highest, req[0] lowest
//                              (caller ties rr_ptr to 0)
//  Ports       : req       in  [3:0] request vector
//                rr_ptr    in  [1:0] rotating priority pointer
//                win_id    out [1:0] index of winning requester
//                win_valid out       any request present
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    win_id,
    output logic               win_valid
);

    logic [ID_W-1:0] w_idx;

    // Scan from lowest to highest priority; the last hit overwrites earlier
    // ones, so the highest-priority active request wins. In fixed mode the
    // scan order is 0,1,2,3 offset by rr_ptr (which is 0), giving req[3]
    // the final word.
    always_comb begin
        win_id    = '0;
        win_valid = 1'b0;
        w_idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_idx = rr_ptr + ID_W'(i);
`else
            w_idx = rr_ptr + ID_W'(NUM_REQ - 1 - i);
`endif
            if (req[w_idx]) begin
                win_id    = w_idx;
                win_valid = 1'b1;
            end
        end
    end

endmodule : arb_prio_enc
`default_nettype wire

// File: rtl/req_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : req_arbiter_4
//  Description : 4-requester arbiter with hold timeout. Grants one owner at a
//                time, holds the grant until the owner signals done, drops
//                its request, or MAX_HOLD cycles elapse. Every grant is
//                followed by a one-cycle RELEASE bubble (break-before-make).
//                Build option ARB_ROUND_ROBIN_EN selects round-robin
//                arbitration; otherwise fixed priority (req[3] highest).
//  Ports       : clk       in       system clock, rising edge
//                rst_n     in       asynchronous active-low reset
//                req       in  [3:0] level-sensitive requests
//                done      in  [3:0] release strobes (owner bit only)
//                gnt       out [3:0] registered one-hot grant
//                gnt_id    out [1:0] registered owner index (decoder select)
//                gnt_valid out       a grant is held
//                timeout   out       one-cycle pulse on forced release
//  Revision    : 1.0 - initial release
// ============================================================================
module req_arbiter_4 #(
    parameter int NUM_REQ  = arb_pkg::NUM_REQ,
    parameter int MAX_HOLD = arb_pkg::DEFAULT_MAX_HOLD,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [arb_pkg::ID_W-1:0] gnt_id,
    output logic                     gnt_valid,
    output logic                     timeout
);
    import arb_pkg::*;

    state_t              r_state,     w_state_nxt;
    logic [CNT_W-1:0]    r_hold_cnt,  w_hold_cnt_nxt;
    logic [NUM_REQ-1:0]  r_gnt,       w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id,    w_gnt_id_nxt;
    logic                r_gnt_valid, w_gnt_valid_nxt;
    logic                r_timeout,   w_timeout_nxt;

    logic [ID_W-1:0]     w_rr_ptr;
    logic [ID_W-1:0]     w_win_id;
    logic                w_win_valid;
    logic                w_own_done;
    logic                w_own_req;
    logic                w_hold_exp;

    // ------------------------------------------------------------------
    // Priority pointer: rotates past the last owner in round-robin builds
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (r_state == GRANT && w_state_nxt == RELEASE) begin
            r_rr_ptr <= r_gnt_id + ID_W'(1);
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    arb_prio_enc u_prio_enc (
        .req       (req),
        .rr_ptr    (w_rr_ptr),
        .win_id    (w_win_id),
        .win_valid (w_win_valid)
    );

    assign w_own_done = done[r_gnt_id];
    assign w_own_req  = req[r_gnt_id];
    assign w_hold_exp = (r_hold_cnt == CNT_W'(MAX_HOLD));

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt     = GRANT;
                    w_gnt_nxt       = NUM_REQ'(1) << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = CNT_W'(1);
                end
            end

            GRANT: begin
                if (w_own_done || !w_own_req || w_hold_exp) begin
                    w_state_nxt     = RELEASE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_cnt_nxt  = '0;
                    // Only a release forced by the hold limit is flagged; an
                    // owner finishing or withdrawing on the same edge wins.
                    w_timeout_nxt   = w_hold_exp && !w_own_done && w_own_req;
                end else if (!w_hold_exp) begin
                    w_hold_cnt_nxt  = r_hold_cnt + CNT_W'(1);
                end
            end

            RELEASE: begin
                // gnt_id intentionally keeps the last owner here
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_hold_cnt_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule : req_arbiter_4
`default_nettype wire

// File: tb/tb_req_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_arbiter_4
//  Description : Self-checking bench for req_arbiter_4 (MAX_HOLD = 4).
//                Table of per-cycle {req, done} inputs with the outputs
//                expected after the following rising edge, plus a
//                hand-written asynchronous reset-mid-grant sequence.
//                With ARB_ROUND_ROBIN_EN defined the round-robin table is
//                used instead of the fixed-priority one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    req_arbiter_4 #(
        .NUM_REQ  (4),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d,
                                input logic [3:0] g, input logic [1:0] id,
                                input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.gnt = g; x.id = id; x.valid = v; x.to = t;
        return x;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic t);
        chk({tag, ".gnt"},       idx, gnt,              g);
        chk({tag, ".gnt_id"},    idx, {2'b00, gnt_id},  {2'b00, id});
        chk({tag, ".gnt_valid"}, idx, {3'b000, gnt_valid}, {3'b000, v});
        chk({tag, ".timeout"},   idx, {3'b000, timeout},   {3'b000, t});
    endtask

    // Watchdog: the bench is clock-counted, this only guards against a hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset mid-grant ----------------
        @(negedge clk);
        req = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        chk_all("pre_rst", 0, 4'b0100, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;  // still before the next rising edge
        chk_all("async_rst", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
`ifndef ARB_ROUND_ROBIN_EN
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0)); // idle
        // fixed priority: 3 beats 1 and 0
        vecs.push_back(mk(4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1011, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0)); // release
        vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0)); // idle
        vecs.push_back(mk(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        // no pre-emption by req[3]; non-owner done[2] ignored
        vecs.push_back(mk(4'b1011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1011, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1011, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1011, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        // requester 0 owns, higher requests and foreign dones ignored
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b1100, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0));
        // owner withdraw
        vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        // timeout: 4 grant cycles then forced release with pulse
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        // regrant, then done coinciding with hold limit: no pulse
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
`else
        // round robin with all requesting: order 0,1,2,3,0
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            req  = vecs[i].req;
            done = vecs[i].done;
            @(posedge clk);
            #1;
            chk_all("vec", i, vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].to);
        end

        @(negedge clk);
        req  = 4'b0000;
        done = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_req_arbiter_4
`default_nettype wire
